// File: rtl/lfsr_stream_if.sv
// rtl/lfsr_stream_if.sv - valid/ready stream carrying LFSR words from source to consumer
interface lfsr_stream_if #(
  parameter int LENGTH = 8
);
  logic              out_valid;
  logic              out_ready;
  logic [LENGTH-1:0] data;

  modport master (
    output out_valid,
    output data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  data,
    output out_ready
  );
endinterface

// File: rtl/lfsr_stream.sv
// rtl/lfsr_stream.sv - LFSR word source with runtime Fibonacci/Galois mode, seed load and period tracking
// Register bit i (0 = MSB) and tap-mask bit i live in vector bit LENGTH-1-i, so masks read left to right.
module lfsr_stream #(
  parameter int                LENGTH       = 8,
  parameter logic [LENGTH-1:0] TAPS_FIB     = 8'b01110001,
  parameter logic [LENGTH-1:0] TAPS_GAL     = 8'b01110000,
  parameter logic [LENGTH-1:0] SEED_DEFAULT = {{(LENGTH-1){1'b0}}, 1'b1}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [LENGTH-1:0] i_seed,
  input  logic              i_mode,
  input  logic              i_stop,
  lfsr_stream_if.master     o_stream,
  output logic [LENGTH-1:0] o_count,
  output logic [LENGTH-1:0] o_period,
  output logic              o_wrap,
  output logic              o_lockup
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [LENGTH-1:0] r_reg;
  logic [LENGTH-1:0] r_seed;
  logic [LENGTH-1:0] r_count;
  logic [LENGTH-1:0] r_period;
  logic              r_mode;
  logic              r_wrap;
  logic              r_lockup;

  logic              w_advance;
  logic              w_fb;
  logic              w_gal_out;
  logic              w_seed_zero;
  logic              w_next_zero;
  logic              w_hit_seed;
  logic              w_count_full;
  logic [LENGTH-1:0] w_fib_next;
  logic [LENGTH-1:0] w_gal_next;
  logic [LENGTH-1:0] w_next_raw;
  logic [LENGTH-1:0] w_next;
  logic [LENGTH-1:0] w_count_inc;
  logic [LENGTH-1:0] w_load_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Load outranks both stop and an advance in the same cycle.
  always_comb begin
    w_state_next = r_state;
    w_advance    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_load) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_advance = o_stream.out_ready & ~i_load;
        if (!i_load && i_stop) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_fb         = ^(r_reg & TAPS_FIB);
    w_fib_next   = {w_fb, r_reg[LENGTH-1:1]};
    w_gal_out    = r_reg[0];
    w_gal_next   = {w_gal_out, r_reg[LENGTH-1:1]}
                 ^ ({1'b0, TAPS_GAL[LENGTH-2:0]} & {LENGTH{w_gal_out}});
    w_next_raw   = r_mode ? w_gal_next : w_fib_next;
    w_next_zero  = (w_next_raw == '0);
    w_next       = w_next_zero ? SEED_DEFAULT : w_next_raw;
    w_hit_seed   = (w_next == r_seed);
    w_count_full = &r_count;
    w_count_inc  = w_count_full ? r_count : r_count + 1'b1;
    w_seed_zero  = (i_seed == '0);
    w_load_val   = w_seed_zero ? SEED_DEFAULT : i_seed;
  end

  // A zero seed would lock the register, so the default seed stands in as both value and wrap target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg    <= SEED_DEFAULT;
      r_seed   <= SEED_DEFAULT;
      r_count  <= '0;
      r_period <= '0;
      r_mode   <= 1'b0;
      r_wrap   <= 1'b0;
      r_lockup <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (i_load) begin
        r_reg   <= w_load_val;
        r_seed  <= w_load_val;
        r_mode  <= i_mode;
        r_count <= '0;
        if (w_seed_zero) begin
          r_lockup <= 1'b1;
        end
      end else if (w_advance) begin
        r_reg <= w_next;
        if (w_next_zero) begin
          r_lockup <= 1'b1;
        end
        if (w_hit_seed) begin
          r_wrap   <= 1'b1;
          r_period <= w_count_inc;
          r_count  <= '0;
        end else begin
          r_count  <= w_count_inc;
        end
      end
    end
  end

  assign o_stream.out_valid = (r_state == ST_RUN);
  assign o_stream.data      = r_reg;
  assign o_count            = r_count;
  assign o_period           = r_period;
  assign o_wrap             = r_wrap;
  assign o_lockup           = r_lockup;

endmodule

// File: tb/tb_lfsr_stream.sv
// tb/tb_lfsr_stream.sv - directed self-checking bench for lfsr_stream
module tb_lfsr_stream;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic       mode = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] seed = 8'h00;
  logic [7:0] count;
  logic [7:0] period;
  logic       wrap;
  logic       lockup;
  int         n_checks = 0;
  int         n_fail = 0;
  int         acc;
  int         bad;
  int         gal_period;
  logic [7:0] g;

  lfsr_stream_if #(.LENGTH(8)) s_if ();

  lfsr_stream dut (
    .clk      (clk),
    .rst      (rst),
    .i_load   (load),
    .i_seed   (seed),
    .i_mode   (mode),
    .i_stop   (stop),
    .o_stream (s_if),
    .o_count  (count),
    .o_period (period),
    .o_wrap   (wrap),
    .o_lockup (lockup)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fibonacci taps at MSB-first positions 1,2,3,7; vector bit = 7 - position.
  function automatic logic [7:0] fib_step(input logic [7:0] v);
    logic fb;
    fb = v[6] ^ v[5] ^ v[4] ^ v[0];
    return {fb, v[7:1]};
  endfunction

  // Galois: last bit feeds position 0 and is folded into positions 1,2,3.
  function automatic logic [7:0] gal_step(input logic [7:0] v);
    logic       o;
    logic [7:0] n;
    o = v[0];
    n = {o, v[7:1]};
    n[6] = n[6] ^ o;
    n[5] = n[5] ^ o;
    n[4] = n[4] ^ o;
    return n;
  endfunction

  task automatic do_load(input logic [7:0] s, input logic m, input logic st);
    load = 1'b1;
    seed = s;
    mode = m;
    stop = st;
    tick();
    load = 1'b0;
    stop = 1'b0;
  endtask

  task automatic run_seq(input logic m, input logic tog, input logic [7:0] sq,
                         input logic [7:0] start, input int acc0,
                         output int acc_o, output int bad_o);
    logic [7:0] e;
    logic       rdy;
    logic       hit;
    bit         seen [256];
    e = start;
    acc_o = acc0;
    bad_o = 0;
    hit = 1'b0;
    foreach (seen[i]) seen[i] = 1'b0;
    for (int cyc = 0; cyc < 1200 && !hit; cyc++) begin
      if (s_if.data !== e || s_if.out_valid !== 1'b1) bad_o++;
      rdy = tog ? (cyc % 2 == 0) : 1'b1;
      s_if.out_ready = rdy;
      if (rdy) begin
        if (seen[e] || e == 8'h00) bad_o++;
        seen[e] = 1'b1;
      end
      tick();
      if (rdy) begin
        acc_o++;
        e = m ? gal_step(e) : fib_step(e);
      end
      hit = rdy && (e == sq);
      if (wrap !== hit) bad_o++;
    end
    s_if.out_ready = 1'b0;
    if (!hit) bad_o++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    s_if.out_ready = 1'b0;
    repeat (2) tick();
    check("rst_valid", s_if.out_valid, 1'b0);
    check("rst_data", s_if.data, 8'h01);
    check("rst_count", count, 8'h00);
    check("rst_period", period, 8'h00);
    check("rst_wrap", wrap, 1'b0);
    check("rst_lockup", lockup, 1'b0);
    rst = 1'b0;
    s_if.out_ready = 1'b1;
    repeat (3) tick();
    check("idle_valid", s_if.out_valid, 1'b0);
    check("idle_data", s_if.data, 8'h01);

    // Scenario 1: Fibonacci from seed 01
    s_if.out_ready = 1'b0;
    do_load(8'h01, 1'b0, 1'b0);
    check("s1_valid", s_if.out_valid, 1'b1);
    check("s1_first", s_if.data, 8'h01);
    tick();
    check("s1_hold", s_if.data, 8'h01);
    s_if.out_ready = 1'b1;
    tick();
    check("s1_w1", s_if.data, 8'h80);
    tick();
    check("s1_w2", s_if.data, 8'h40);
    tick();
    check("s1_w3", s_if.data, 8'hA0);
    tick();
    check("s1_w4", s_if.data, 8'hD0);
    check("s1_count4", count, 8'd4);
    run_seq(1'b0, 1'b0, 8'h01, 8'hD0, 4, acc, bad);
    check("s1_accepts", acc, 255);
    check("s1_seq_bad", bad, 0);
    check("s1_period", period, 8'd255);
    check("s1_count_wrap", count, 8'd0);
    check("s1_data_wrap", s_if.data, 8'h01);
    tick();
    check("s1_wrap_pulse", wrap, 1'b0);

    // Scenario 2: Galois from seed 01
    g = gal_step(8'h01);
    gal_period = 1;
    while (g != 8'h01 && gal_period < 300) begin
      g = gal_step(g);
      gal_period++;
    end
    do_load(8'h01, 1'b1, 1'b0);
    check("s2_first", s_if.data, 8'h01);
    check("s2_period_kept", period, 8'd255);
    run_seq(1'b1, 1'b0, 8'h01, 8'h01, 0, acc, bad);
    check("s2_accepts", acc, gal_period);
    check("s2_seq_bad", bad, 0);
    check("s2_period", period, gal_period[7:0]);

    // Scenario 3: toggled ready, Fibonacci
    do_load(8'h01, 1'b0, 1'b0);
    run_seq(1'b0, 1'b1, 8'h01, 8'h01, 0, acc, bad);
    check("s3_accepts", acc, 255);
    check("s3_seq_bad", bad, 0);
    check("s3_period", period, 8'd255);

    // Scenario 4: zero seed
    do_load(8'h00, 1'b0, 1'b0);
    check("s4_lockup", lockup, 1'b1);
    check("s4_first", s_if.data, 8'h01);
    run_seq(1'b0, 1'b0, 8'h01, 8'h01, 0, acc, bad);
    check("s4_accepts", acc, 255);
    check("s4_seq_bad", bad, 0);
    check("s4_lockup_held", lockup, 1'b1);

    // Scenario 5: load+stop together, then lone stop with handshake
    do_load(8'h01, 1'b0, 1'b0);
    s_if.out_ready = 1'b1;
    tick();
    tick();
    check("s5_pre_data", s_if.data, 8'h40);
    check("s5_pre_count", count, 8'd2);
    do_load(8'h55, 1'b0, 1'b1);
    check("s5_ls_valid", s_if.out_valid, 1'b1);
    check("s5_ls_data", s_if.data, 8'h55);
    check("s5_ls_count", count, 8'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("s5_stop_valid", s_if.out_valid, 1'b0);
    check("s5_stop_data", s_if.data, 8'hAA);
    check("s5_stop_count", count, 8'd1);
    tick();
    check("s5_frozen", s_if.data, 8'hAA);
    check("s5_lockup_sticky", lockup, 1'b1);

    // Scenario 6: async reset between edges
    do_load(8'h10, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    #3;
    rst = 1'b1;
    #1;
    check("s6_valid", s_if.out_valid, 1'b0);
    check("s6_data", s_if.data, 8'h01);
    check("s6_count", count, 8'd0);
    check("s6_period", period, 8'd0);
    check("s6_lockup", lockup, 1'b0);
    s_if.out_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("s6_idle_valid", s_if.out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
